hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline.
- Compares D/E-stage source registers against E/M/W destination registers using Tuse/Tnew.
- Drives the select inputs of the D-stage and E-stage forwarding muxes and produces the pipeline stall.
- Owns the multiply/divide busy sequencer, so mfhi/mflo/mult/div in D stall while the MDU is running.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start
CNT_W, 4, width of busy down-counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
D_rs_addr  input  5  rs of instruction in D
D_rt_addr  input  5  rt of instruction in D
D_tuse_rs  input  2  Tuse of rs in D; 3 = not used
D_tuse_rt  input  2  Tuse of rt in D; 3 = not used
D_md_use  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
E_rs_addr  input  5  rs in E
E_rt_addr  input  5  rt in E
E_wr_addr  input  5  destination in E; 0 = no write
E_tnew  input  2  cycles until E result is ready
M_wr_addr  input  5  destination in M; 0 = no write
M_tnew  input  2  cycles until M result is ready
W_wr_addr  input  5  destination in W; 0 = no write
E_md_start  input  1  mult/div issuing in E this cycle
E_md_op  input  1  0 = mult family, 1 = div family
flush  input  1  exception/interrupt flush, synchronous
stall  output  1  freeze F/D, insert bubble into E
D_ForwardRD1Mux_Sel  output  2  2 = M, 1 = W, 0 = register file
D_ForwardRD2Mux_Sel  output  2  same encoding, rt
E_ForwardRS_Sel  output  2  same encoding, E rs operand
E_ForwardRT_Sel  output  2  same encoding, E rt operand
md_busy  output  1  MDU result pending

Behaviour:
- Reset (reset=0, asynchronous): busy counter = 0, so md_busy = 0. All other outputs are combinational from inputs and the counter.
- Register 0 never matches any stage; it always selects 0 and never stalls.
- D forward select for rs, same rule for rt:
  - 2 if M_wr_addr == rs and M_tnew == 0;
  - else 1 if W_wr_addr == rs;
  - else 0.
  - M has priority over W.
- E forward selects: identical rule applied to E_rs_addr and E_rt_addr.
- Data stall for rs: rs != 0 and Tuse != 3 and either
  - (E_wr_addr == rs and E_tnew > D_tuse_rs), or
  - (M_wr_addr == rs and M_tnew > D_tuse_rs).
- Same data-stall rule applies for rt.
- MDU stall: D_md_use and (md_busy or E_md_start).
- stall = rs stall OR rt stall OR MDU stall; purely combinational, no added latency.
- Busy sequencer (single down-counter):
  - On a clock edge with flush = 1: counter <- 0.
  - Else with E_md_start = 1: counter <- (E_md_op ? DIV_CYCLES : MULT_CYCLES).
  - Else if counter != 0: counter decrements by 1.
- md_busy = (counter != 0). A start sampled at edge t gives md_busy high for exactly N cycles after edge t.
- E_md_start while md_busy cannot occur legally (the stall prevents it). If it does occur, the counter reloads; there is no error output.
- flush and E_md_start on the same edge: flush wins and the counter goes to 0.
- Reset asserted mid-count: counter clears immediately; md_busy falls without waiting for a clock edge.
- Counter arithmetic is CNT_W-bit unsigned and never wraps below 0.

Optional Feature:
- Macro HAZARD_CTRL_STATS_EN.
- When defined, adds two output ports:
  - stall_cnt (32 bits): increments on every clock edge with stall = 1.
  - md_stall_cnt (32 bits): increments on every edge with MDU stall = 1.
- Both counters clear on reset, wrap from 0xFFFFFFFF to 0, and are not affected by flush.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Load-use: D rs = 5, D_tuse_rs = 0; E_wr_addr = 5, E_tnew = 2 -> stall = 1. Next cycle M_wr_addr = 5, M_tnew = 1 -> stall = 1. Then M_tnew = 0 -> stall = 0, D_ForwardRD1Mux_Sel = 2.
- Priority: M_wr_addr = W_wr_addr = 8, M_tnew = 0, D rt = 8 -> D_ForwardRD2Mux_Sel = 2. With M_wr_addr = 0 -> Sel = 1. With rt = 0 and all addresses 0 -> Sel = 0, stall = 0.
- Mult sequencing: E_md_start = 1, E_md_op = 0 for one cycle, D_md_use = 1 -> stall = 1 in the start cycle, md_busy high for exactly 5 cycles, stall released in the cycle md_busy falls.
- Div plus flush: start div, then assert flush on the 3rd busy cycle -> md_busy = 0 on the following cycle. Same-edge start + flush -> md_busy stays 0.
- Async reset: assert reset = 0 mid-div between clock edges -> md_busy drops immediately. Release -> no spurious stall with D_md_use = 1 and no start.
- Stats (HAZARD_CTRL_STATS_EN): run the mult scenario -> md_stall_cnt = 6 (start cycle + 5 busy cycles), stall_cnt ≥ 6; reset -> both counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, data/MDU stall and the MDU busy sequencer.
// Optional stall statistics counters are enabled with `define HAZARD_CTRL_STATS_EN.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs_addr,
  input  logic [4:0] D_rt_addr,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic       D_md_use,
  input  logic [4:0] E_rs_addr,
  input  logic [4:0] E_rt_addr,
  input  logic [4:0] E_wr_addr,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_wr_addr,
  input  logic [1:0] M_tnew,
  input  logic [4:0] W_wr_addr,
  input  logic       E_md_start,
  input  logic       E_md_op,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] D_ForwardRD1Mux_Sel,
  output logic [1:0] D_ForwardRD2Mux_Sel,
  output logic [1:0] E_ForwardRS_Sel,
  output logic [1:0] E_ForwardRT_Sel,
  output logic       md_busy
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt
`endif
);

  // M result is only forwardable once it is actually produced (tnew == 0); M beats W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] m_wr,
                                         input logic [1:0] m_tnew, input logic [4:0] w_wr);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0) begin
      if (m_wr == src && m_tnew == 2'd0) sel = 2'd2;
      else if (w_wr == src)              sel = 2'd1;
    end
    return sel;
  endfunction

  function automatic logic data_stall(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] e_wr, input logic [1:0] e_tnew,
                                      input logic [4:0] m_wr, input logic [1:0] m_tnew);
    return (src != 5'd0) && (tuse != 2'd3) &&
           ((e_wr == src && e_tnew > tuse) || (m_wr == src && m_tnew > tuse));
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic             w_rs_stall;
  logic             w_rt_stall;
  logic             w_md_stall;

  assign D_ForwardRD1Mux_Sel = fwd_sel(D_rs_addr, M_wr_addr, M_tnew, W_wr_addr);
  assign D_ForwardRD2Mux_Sel = fwd_sel(D_rt_addr, M_wr_addr, M_tnew, W_wr_addr);
  assign E_ForwardRS_Sel     = fwd_sel(E_rs_addr, M_wr_addr, M_tnew, W_wr_addr);
  assign E_ForwardRT_Sel     = fwd_sel(E_rt_addr, M_wr_addr, M_tnew, W_wr_addr);

  assign w_rs_stall = data_stall(D_rs_addr, D_tuse_rs, E_wr_addr, E_tnew, M_wr_addr, M_tnew);
  assign w_rt_stall = data_stall(D_rt_addr, D_tuse_rt, E_wr_addr, E_tnew, M_wr_addr, M_tnew);
  assign md_busy    = (r_cnt != '0);
  // A start in E blocks a dependent MDU op in D even before the counter is loaded.
  assign w_md_stall = D_md_use && (md_busy || E_md_start);
  assign stall      = w_rs_stall || w_rt_stall || w_md_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_cnt <= '0;
    else if (flush)          r_cnt <= '0;
    else if (E_md_start)     r_cnt <= E_md_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

`ifdef HAZARD_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall)      stall_cnt    <= stall_cnt + 32'd1;
      if (w_md_stall) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: expected output vectors are queued as stimulus is applied
// and popped/compared away from the clock edge.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs_addr, D_rt_addr, E_rs_addr, E_rt_addr, E_wr_addr, M_wr_addr, W_wr_addr;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_md_use, E_md_start, E_md_op, flush;
  logic       stall, md_busy;
  logic [1:0] D_ForwardRD1Mux_Sel, D_ForwardRD2Mux_Sel, E_ForwardRS_Sel, E_ForwardRT_Sel;
`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  int n_asserts = 0;
  int n_fails   = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_md_use(D_md_use), .E_rs_addr(E_rs_addr), .E_rt_addr(E_rt_addr), .E_wr_addr(E_wr_addr),
    .E_tnew(E_tnew), .M_wr_addr(M_wr_addr), .M_tnew(M_tnew), .W_wr_addr(W_wr_addr),
    .E_md_start(E_md_start), .E_md_op(E_md_op), .flush(flush), .stall(stall),
    .D_ForwardRD1Mux_Sel(D_ForwardRD1Mux_Sel), .D_ForwardRD2Mux_Sel(D_ForwardRD2Mux_Sel),
    .E_ForwardRS_Sel(E_ForwardRS_Sel), .E_ForwardRT_Sel(E_ForwardRT_Sel), .md_busy(md_busy)
`ifdef HAZARD_CTRL_STATS_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  task automatic clr_in();
    D_rs_addr = 0; D_rt_addr = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_md_use = 0;
    E_rs_addr = 0; E_rt_addr = 0; E_wr_addr = 0; E_tnew = 0;
    M_wr_addr = 0; M_tnew = 0; W_wr_addr = 0;
    E_md_start = 0; E_md_op = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected: stall, md_busy, D rs sel, D rt sel, E rs sel, E rt sel.
  task automatic expect_out(input string tag, input logic s, input logic b, input logic [1:0] d1,
                            input logic [1:0] d2, input logic [1:0] ers, input logic [1:0] ert);
    sb_t e;
    e.tag = tag;
    e.exp = {s, b, d1, d2, ers, ert};
    sbq.push_back(e);
  endtask

  task automatic compare();
    sb_t e;
    logic [9:0] obs;
    #2;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      obs = {stall, md_busy, D_ForwardRD1Mux_Sel, D_ForwardRD2Mux_Sel, E_ForwardRS_Sel, E_ForwardRT_Sel};
      n_asserts++;
      assert (obs === e.exp) else begin
        n_fails++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    clr_in();
    expect_out("reset", 0, 0, 0, 0, 0, 0); compare();
    tick(); reset = 1'b1;

    // Load-use on rs
    D_rs_addr = 5; D_tuse_rs = 0; E_wr_addr = 5; E_tnew = 2;
    expect_out("loaduse_E", 1, 0, 0, 0, 0, 0); compare();
    E_wr_addr = 0; M_wr_addr = 5; M_tnew = 1;
    expect_out("loaduse_M", 1, 0, 0, 0, 0, 0); compare();
    M_tnew = 0;
    expect_out("loaduse_fwd", 0, 0, 2, 0, 0, 0); compare();
    clr_in(); D_rs_addr = 5; D_tuse_rs = 1; E_wr_addr = 5; E_tnew = 1;
    expect_out("tnew_eq_tuse", 0, 0, 0, 0, 0, 0); compare();
    D_tuse_rs = 3; E_tnew = 2;
    expect_out("tuse_unused", 0, 0, 0, 0, 0, 0); compare();
    clr_in(); D_rt_addr = 7; D_tuse_rt = 1; M_wr_addr = 7; M_tnew = 2;
    expect_out("rt_stall_M", 1, 0, 0, 0, 0, 0); compare();

    // Forward priority
    clr_in(); D_rt_addr = 8; M_wr_addr = 8; W_wr_addr = 8; M_tnew = 0;
    expect_out("prio_M", 0, 0, 0, 2, 0, 0); compare();
    M_wr_addr = 0;
    expect_out("prio_W", 0, 0, 0, 1, 0, 0); compare();
    clr_in();
    expect_out("all_zero", 0, 0, 0, 0, 0, 0); compare();
    D_rs_addr = 0; D_tuse_rs = 0; E_tnew = 2; M_tnew = 2;
    expect_out("reg0", 0, 0, 0, 0, 0, 0); compare();
    clr_in(); E_rs_addr = 3; E_rt_addr = 4; M_wr_addr = 3; W_wr_addr = 4;
    expect_out("E_fwd", 0, 0, 0, 0, 2, 1); compare();
    W_wr_addr = 3; M_tnew = 1;
    expect_out("E_fwd_Mnotready", 0, 0, 0, 0, 1, 0); compare();

    // Mult sequencing with a dependent MDU op in D
    clr_in(); D_md_use = 1; E_md_start = 1; E_md_op = 0;
    expect_out("mult_start", 1, 0, 0, 0, 0, 0); compare();
    tick(); E_md_start = 0;
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("mult_busy%0d", i), 1, 1, 0, 0, 0, 0); compare();
      tick();
    end
    expect_out("mult_done", 0, 0, 0, 0, 0, 0); compare();

    // Full div length, no dependent op in D
    clr_in(); E_md_start = 1; E_md_op = 1;
    expect_out("div_start_nouse", 0, 0, 0, 0, 0, 0); compare();
    tick(); E_md_start = 0;
    for (int i = 0; i < 10; i++) begin
      expect_out($sformatf("div_busy%0d", i), 0, 1, 0, 0, 0, 0); compare();
      tick();
    end
    expect_out("div_done", 0, 0, 0, 0, 0, 0); compare();

    // Div cut short by flush on the 3rd busy cycle
    E_md_start = 1; E_md_op = 1;
    tick(); E_md_start = 0;
    tick(); tick();
    flush = 1;
    expect_out("div_busy3", 0, 1, 0, 0, 0, 0); compare();
    tick(); flush = 0;
    expect_out("div_flushed", 0, 0, 0, 0, 0, 0); compare();
    E_md_start = 1; flush = 1;
    tick(); E_md_start = 0; flush = 0;
    expect_out("start_flush_same", 0, 0, 0, 0, 0, 0); compare();

    // Async reset mid-div
    E_md_start = 1; E_md_op = 1;
    tick(); E_md_start = 0;
    tick();
    expect_out("pre_async", 0, 1, 0, 0, 0, 0); compare();
    #1 reset = 1'b0;
    expect_out("async_reset", 0, 0, 0, 0, 0, 0); compare();
    tick(); reset = 1'b1; D_md_use = 1;
    expect_out("post_reset_nostall", 0, 0, 0, 0, 0, 0); compare();

`ifdef HAZARD_CTRL_STATS_EN
    clr_in(); reset = 1'b0; #1;
    n_asserts++;
    assert (stall_cnt === 32'd0 && md_stall_cnt === 32'd0) else begin
      n_fails++;
      $error("FAIL stats_reset: observed %0d/%0d expected 0/0", stall_cnt, md_stall_cnt);
    end
    tick(); reset = 1'b1;
    D_md_use = 1; E_md_start = 1; E_md_op = 0;
    tick(); E_md_start = 0;
    for (int i = 0; i < 6; i++) tick();
    n_asserts++;
    assert (md_stall_cnt === 32'd6 && stall_cnt === 32'd6) else begin
      n_fails++;
      $error("FAIL stats_mult: observed %0d/%0d expected 6/6", stall_cnt, md_stall_cnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
